// File: rtl/axi_master.sv
// AXI4 manager engine: turns a command/data stream into single outstanding AXI4
// bursts, returns read beats and completion status, and flags protocol errors.
module axi_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic                  done_write,
  output logic [ID_WIDTH-1:0]   done_id,
  output logic [1:0]            done_resp,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int MAX_SIZE = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   txn_id;
  logic [ADDR_WIDTH-1:0] txn_addr;
  logic [7:0]            txn_len;
  logic [2:0]            txn_size;
  logic [1:0]            txn_burst;
  logic [7:0]            beat_cnt;
  logic [1:0]            resp_acc;
  logic                  cmd_hs, w_hs, b_hs, r_hs, last_beat, err_now;

  // A beat wider than the bus is not representable, so the size saturates.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    if (int'(size) > MAX_SIZE) return 3'(MAX_SIZE);
    return size;
  endfunction

  function automatic logic [1:0] max_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign cmd_hs    = (state == IDLE) && cmd_valid;
  assign w_hs      = (state == WDATA) && wr_valid && m_axi_wready;
  assign b_hs      = (state == WRESP) && m_axi_bvalid;
  assign r_hs      = (state == RDATA) && m_axi_rvalid && rd_ready;
  assign last_beat = (beat_cnt == 8'd0);

  assign err_now = (m_axi_bvalid && (state != WRESP))
                || (m_axi_rvalid && (state != RDATA))
                || (b_hs && (m_axi_bid != txn_id))
                || (r_hs && ((m_axi_rid != txn_id) || (m_axi_rlast != last_beat)));

  assign m_axi_awid    = txn_id;
  assign m_axi_awaddr  = txn_addr;
  assign m_axi_awlen   = txn_len;
  assign m_axi_awsize  = txn_size;
  assign m_axi_awburst = txn_burst;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arid    = txn_id;
  assign m_axi_araddr  = txn_addr;
  assign m_axi_arlen   = txn_len;
  assign m_axi_arsize  = txn_size;
  assign m_axi_arburst = txn_burst;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  // Data paths are pure wiring; only the valid/ready qualifiers depend on state.
  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign m_axi_wlast = (state == WDATA) && last_beat;
  assign rd_data     = m_axi_rdata;
  assign rd_resp     = m_axi_rresp;
  assign rd_last     = m_axi_rlast;

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_hs) state_nxt = cmd_write ? WADDR : RADDR;
      end
      WADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = WDATA;
      end
      WDATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        if (w_hs && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (b_hs) state_nxt = IDLE;
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RDATA;
      end
      RDATA: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (r_hs && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      txn_id     <= '0;
      txn_addr   <= '0;
      txn_len    <= '0;
      txn_size   <= '0;
      txn_burst  <= '0;
      beat_cnt   <= '0;
      resp_acc   <= '0;
      done_valid <= 1'b0;
      done_write <= 1'b0;
      done_id    <= '0;
      done_resp  <= '0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_valid <= 1'b0;
      if (cmd_hs) begin
        txn_id    <= cmd_id;
        txn_addr  <= cmd_addr;
        txn_len   <= cmd_len;
        txn_size  <= clamp_size(cmd_size);
        txn_burst <= cmd_burst;
        beat_cnt  <= cmd_len;
        resp_acc  <= '0;
      end
      if (w_hs && !last_beat) beat_cnt <= beat_cnt - 8'd1;
      if (b_hs) begin
        done_valid <= 1'b1;
        done_write <= 1'b1;
        done_id    <= txn_id;
        done_resp  <= m_axi_bresp;
      end
      if (r_hs) begin
        resp_acc <= max_resp(resp_acc, m_axi_rresp);
        if (last_beat) begin
          done_valid <= 1'b1;
          done_write <= 1'b0;
          done_id    <= txn_id;
          done_resp  <= max_resp(resp_acc, m_axi_rresp);
        end else begin
          beat_cnt <= beat_cnt - 8'd1;
        end
      end
      if (err_now) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_master.sv
// Bench for axi_master: table of bursts against a small AXI4 memory responder,
// with queued expectations for AW/AR, W beats, read beats and completions.
module tb_axi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_id, cmd_len;
  logic [15:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
  logic [1:0]  rd_resp, done_resp;
  logic        done_valid, done_write, error;
  logic [7:0]  done_id;
  logic [7:0]  awid, awlen, arid, arlen, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, arcache, wstrb;
  logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arlock, arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;

  axi_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_resp(rd_resp),
    .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready), .done_valid(done_valid),
    .done_write(done_write), .done_id(done_id), .done_resp(done_resp), .error(error),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} wbeat_t;
  typedef struct packed {logic [31:0] d; logic [1:0] resp; logic l;} rbeat_t;
  typedef struct packed {logic [7:0] id; logic [15:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;} aexp_t;
  typedef struct packed {logic w; logic [7:0] id; logic [1:0] resp;} dexp_t;
  typedef struct {
    logic wr; logic [7:0] id; logic [15:0] addr; logic [7:0] len; logic [2:0] size;
    logic [2:0] exp_size; logic [3:0][31:0] data; logic wtog; int stall; logic [1:0] rresp1;
  } vec_t;

  wbeat_t wq[$], w_exp[$];
  rbeat_t rd_exp[$];
  aexp_t  aw_exp[$], ar_exp[$];
  dexp_t  done_exp[$];

  int checks = 0, errors = 0;

  logic [31:0] mem [0:1023];
  logic [15:0] w_addr, r_addr;
  logic [2:0]  w_size, r_size;
  logic [1:0]  w_burst, r_burst, rresp1;
  logic [7:0]  w_id, b_id, r_id;
  logic        b_pend, r_active, phase, wtog, rlast_early, bid_bad;
  int          w_beats, r_len, r_cnt, r_seen, stall_len, stall_used;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected/missing event want matching event", name);
  endtask

  // Responder, data source/sink and monitors: drive on negedge, sample 2 ns later.
  initial begin : engine
    aexp_t ae; wbeat_t we; rbeat_t re; dexp_t de; int idx;
    b_pend = 0; r_active = 0; phase = 0; w_beats = 0; r_cnt = 0; r_len = 0; r_seen = 0;
    stall_used = 0; w_addr = 0; r_addr = 0; w_size = 0; r_size = 0; w_burst = 0; r_burst = 0;
    w_id = 0; b_id = 0; r_id = 0;
    awready = 0; arready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 1;
    forever begin
      @(negedge clk);
      awready = 1'b1; arready = 1'b1; wready = 1'b1;
      bvalid = b_pend; bid = b_id; bresp = 2'b00;
      rvalid = r_active; rid = r_id; rdata = mem[r_addr[11:2]];
      rresp = (r_active && r_cnt == 1) ? rresp1 : 2'b00;
      rlast = r_active && (r_cnt == r_len || (rlast_early && r_cnt == 1));
      wr_valid = (wq.size() != 0) && (!wtog || phase);
      if (wq.size() != 0) begin
        wr_data = wq[0].d;
        wr_strb = wq[0].s;
      end
      rd_ready = 1'b1;
      if (r_active && r_seen >= 2 && stall_used < stall_len) begin
        rd_ready = 1'b0;
        stall_used++;
      end
      #2;
      if (!rst_n) begin
        b_pend = 0; r_active = 0;
        wq.delete(); w_exp.delete(); rd_exp.delete(); aw_exp.delete(); ar_exp.delete(); done_exp.delete();
      end else begin
        if (!rd_ready) chk("rready_stall", 64'(rready), 64'(0));
        if (awvalid && awready) begin
          if (aw_exp.size() == 0) fail("aw_unexpected");
          else begin
            ae = aw_exp.pop_front();
            chk("aw", 64'({awid, awaddr, awlen, awsize, awburst}), 64'(ae));
            chk("aw_attr", 64'({awlock, awcache, awprot}), 64'(8'b0_0011_000));
          end
          w_addr = awaddr; w_size = awsize; w_burst = awburst; w_id = awid; w_beats = 0;
        end
        if (wvalid && wready) begin
          if (w_exp.size() == 0) fail("w_unexpected");
          else begin
            we = w_exp.pop_front();
            chk("w_beat", 64'({wdata, wstrb, wlast}), 64'(we));
          end
          idx = int'(w_addr[11:2]);
          for (int b = 0; b < 4; b++) if (wstrb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
          if (w_burst != 2'b00) w_addr = w_addr + (16'd1 << w_size);
          w_beats++;
          if (wlast) begin
            b_pend = 1'b1;
            b_id = bid_bad ? 8'h11 : w_id;
          end
        end
        if (wr_valid && wr_ready && wq.size() != 0) void'(wq.pop_front());
        if (bvalid && bready) b_pend = 1'b0;
        if (arvalid && arready) begin
          if (ar_exp.size() == 0) fail("ar_unexpected");
          else begin
            ae = ar_exp.pop_front();
            chk("ar", 64'({arid, araddr, arlen, arsize, arburst}), 64'(ae));
            chk("ar_attr", 64'({arlock, arcache, arprot}), 64'(8'b0_0011_000));
          end
          r_active = 1'b1; r_addr = araddr; r_size = arsize; r_burst = arburst;
          r_len = int'(arlen); r_cnt = 0; r_seen = 0; r_id = arid; stall_used = 0;
        end
        if (rd_valid && rd_ready) begin
          if (rd_exp.size() == 0) fail("rd_unexpected");
          else begin
            re = rd_exp.pop_front();
            chk("rd_beat", 64'({rd_data, rd_resp, rd_last}), 64'(re));
          end
        end
        if (rvalid && rready) begin
          r_seen++;
          if (r_cnt == r_len) r_active = 1'b0;
          else begin
            r_cnt++;
            if (r_burst != 2'b00) r_addr = r_addr + (16'd1 << r_size);
          end
        end
        if (done_valid) begin
          if (done_exp.size() == 0) fail("done_unexpected");
          else begin
            de = done_exp.pop_front();
            chk("done", 64'({done_write, done_id, done_resp}), 64'(de));
            chk("cmd_ready_at_done", 64'(cmd_ready), 64'(1));
          end
        end
      end
      phase = !phase;
    end
  end

  task automatic start_cmd(input vec_t v, input logic early);
    aexp_t a; logic [1:0] r, mx; logic acc;
    a = {v.id, v.addr, v.len, v.exp_size, 2'b01};
    if (v.wr) aw_exp.push_back(a);
    else ar_exp.push_back(a);
    mx = 2'b00;
    for (int i = 0; i <= int'(v.len); i++) begin
      if (v.wr) begin
        wq.push_back({v.data[i], 4'hF, 1'b0});
        w_exp.push_back({v.data[i], 4'hF, i == int'(v.len)});
      end else begin
        r = (i == 1) ? v.rresp1 : 2'b00;
        if (r > mx) mx = r;
        rd_exp.push_back({v.data[i], r, (i == int'(v.len)) || (early && i == 1)});
      end
    end
    done_exp.push_back({v.wr, v.id, v.wr ? 2'b00 : mx});
    wtog = v.wtog; stall_len = v.stall; rresp1 = v.rresp1; rlast_early = early;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_id = v.id; cmd_addr = v.addr;
    cmd_len = v.len; cmd_size = v.size; cmd_burst = 2'b01;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      #2;
      if (cmd_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) fail("cmd_accept_timeout");
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    if (acc) chk("addr_valid_next_cycle", 64'(v.wr ? awvalid : arvalid), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((done_exp.size() != 0 || w_exp.size() != 0 || rd_exp.size() != 0) && c < 300) begin
      @(negedge clk);
      #3;
      c++;
    end
    if (c >= 300) begin
      fail(name);
      done_exp.delete(); w_exp.delete(); rd_exp.delete();
    end
  endtask

  task automatic issue(input vec_t v, input logic early);
    start_cmd(v, early);
    wait_idle("completion_timeout");
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    chk("reset_ctrl", 64'({awvalid, wvalid, wlast, bready, arvalid, rready, wr_ready,
                          rd_valid, done_valid, cmd_ready, error}), 64'(0));
    chk("reset_payload", 64'({awid, awaddr, awlen}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));
  endtask

  initial begin : main
    vec_t tbl [7];
    vec_t v;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = 0; cmd_addr = 0;
    cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    wtog = 0; stall_len = 0; rresp1 = 0; rlast_early = 0; bid_bad = 0;
    tbl[0] = '{1'b1, 8'h5A, 16'h0100, 8'd0, 3'd2, 3'd2, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 0, 2'b00};
    tbl[1] = '{1'b0, 8'h5A, 16'h0100, 8'd0, 3'd2, 3'd2, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 0, 2'b00};
    tbl[2] = '{1'b1, 8'h01, 16'h0200, 8'd3, 3'd2, 3'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, 0, 2'b00};
    tbl[3] = '{1'b0, 8'h02, 16'h0200, 8'd3, 3'd2, 3'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 5, 2'b01};
    tbl[4] = '{1'b1, 8'h33, 16'h0300, 8'd1, 3'd3, 3'd2, {32'h0, 32'h0, 32'hA1, 32'hA0}, 1'b0, 0, 2'b00};
    tbl[5] = '{1'b0, 8'h34, 16'h0304, 8'd0, 3'd2, 3'd2, {32'h0, 32'h0, 32'h0, 32'hA1}, 1'b0, 0, 2'b00};
    tbl[6] = '{1'b0, 8'h35, 16'h0300, 8'd1, 3'd3, 3'd2, {32'h0, 32'h0, 32'hA1, 32'hA0}, 1'b0, 0, 2'b00};

    repeat (2) @(negedge clk);
    #3;
    chk("reset_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, wr_ready,
                          rd_valid, done_valid, cmd_ready, error}), 64'(0));
    chk("reset_payload", 64'({awid, awaddr, awlen}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 7; i++) begin
      issue(tbl[i], 1'b0);
      chk("error_clear", 64'(error), 64'(0));
    end

    // Mismatched bid: completion still reported, error sticks until reset.
    v = '{1'b1, 8'h22, 16'h0400, 8'd0, 3'd2, 3'd2, {32'h0, 32'h0, 32'h0, 32'h55}, 1'b0, 0, 2'b00};
    bid_bad = 1'b1;
    issue(v, 1'b0);
    bid_bad = 1'b0;
    chk("error_bid", 64'(error), 64'(1));
    v = '{1'b1, 8'h23, 16'h0404, 8'd0, 3'd2, 3'd2, {32'h0, 32'h0, 32'h0, 32'h66}, 1'b0, 0, 2'b00};
    issue(v, 1'b0);
    chk("error_sticky", 64'(error), 64'(1));
    reset_pulse();
    chk("error_after_reset", 64'(error), 64'(0));

    // Early rlast on the second beat of a 4-beat read.
    v = '{1'b0, 8'h24, 16'h0200, 8'd3, 3'd2, 3'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 0, 2'b00};
    issue(v, 1'b1);
    chk("error_rlast", 64'(error), 64'(1));
    reset_pulse();

    // Reset after two of four write beats abandons the burst.
    v = '{1'b1, 8'h44, 16'h0500, 8'd3, 3'd2, 3'd2, {32'h13, 32'h12, 32'h11, 32'h10}, 1'b0, 0, 2'b00};
    start_cmd(v, 1'b0);
    for (int c = 0; c < 100 && w_beats < 2; c++) begin
      @(negedge clk);
      #3;
    end
    chk("beats_before_reset", 64'(w_beats), 64'(2));
    reset_pulse();
    v = '{1'b1, 8'h45, 16'h0500, 8'd1, 3'd2, 3'd2, {32'h0, 32'h0, 32'h21, 32'h20}, 1'b0, 0, 2'b00};
    issue(v, 1'b0);
    v = '{1'b0, 8'h46, 16'h0500, 8'd1, 3'd2, 3'd2, {32'h0, 32'h0, 32'h21, 32'h20}, 1'b0, 0, 2'b00};
    issue(v, 1'b0);
    chk("error_after_recovery", 64'(error), 64'(0));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_master.md
# axi_master

AXI4 manager engine that drives the initiator side of an AXI4 memory-mapped bus from a simple command/data stream interface. It sits between in-house datapath logic and any AXI4 subordinate (e.g. the team's AXI4 RAM). It issues one read or write burst at a time, streams write data out, and streams read data back. It reports completion status and flags protocol violations seen on the bus.

## Interface
- DATA_WIDTH, 32, AXI data bus width in bits
- ADDR_WIDTH, 16, AXI address width in bits
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; must be a power of two
- ID_WIDTH, 8, AXI ID width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_id / cmd_addr  in  ID_WIDTH / ADDR_WIDTH  transaction ID, start byte address
- cmd_len / cmd_size / cmd_burst  in  8 / 3 / 2  beats-1, log2 bytes per beat, burst type
- wr_data / wr_strb  in  DATA_WIDTH / STRB_WIDTH  write beat payload
- wr_valid / wr_ready  in / out  1 / 1  write beat handshake
- rd_data / rd_resp / rd_last  out  DATA_WIDTH / 2 / 1  read beat payload
- rd_valid / rd_ready  out / in  1 / 1  read beat handshake
- done_valid  out  1  one-cycle completion pulse; no backpressure
- done_write / done_id / done_resp  out  1 / ID_WIDTH / 2  completion kind, ID, response
- error  out  1  sticky protocol-error flag; cleared only by reset
- m_axi_awid/awaddr/awlen/awsize/awburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload
- m_axi_awlock/awcache/awprot  out  1/4/3  constants 0 / 4'b0011 / 3'b000
- m_axi_awvalid / m_axi_awready  out / in  1 / 1  AW handshake
- m_axi_wdata/wstrb/wlast  out  DATA_WIDTH/STRB_WIDTH/1  W payload
- m_axi_wvalid / m_axi_wready  out / in  1 / 1  W handshake
- m_axi_bid/bresp  in  ID_WIDTH/2; m_axi_bvalid in 1; m_axi_bready out 1  B channel
- m_axi_ar*  out  same widths and constants as AW, plus m_axi_arvalid out / m_axi_arready in
- m_axi_rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1; m_axi_rready out 1  R channel

## Operation
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA. One transaction outstanding at a time.
- cmd_ready = (state == IDLE) && rst_n.
- On command accept, register id, addr, len, and burst. Register size clamped to min(cmd_size, log2(STRB_WIDTH)).
- Accept goes to WADDR if cmd_write is 1, otherwise RADDR. Beat counter loads cmd_len.
- WADDR: awvalid = 1, payload from registers. On AW handshake, go to WDATA.
- WDATA: m_axi_wdata/wstrb = wr_data/wr_strb (pass-through).
  - m_axi_wvalid = wr_valid; wr_ready = m_axi_wready.
  - wlast = (counter == 0). Counter decrements per W handshake.
  - The handshake with counter == 0 goes to WRESP.
- WRESP: bready = 1. On B handshake:
  - pulse done with done_write = 1, done_id = registered id, done_resp = bresp.
  - go to IDLE.
- RADDR: arvalid = 1. On AR handshake, go to RDATA.
- RDATA: rd_data/rd_resp/rd_last mirror R; rd_valid = rvalid; m_axi_rready = rd_ready.
  - done_resp accumulates the max rresp over the burst.
  - On the handshake with counter == 0, pulse done (done_write = 0) and go to IDLE.
- error sets on any of:
  - bid or rid ≠ registered id
  - rlast ≠ (counter == 0) on an R handshake
  - bvalid outside WRESP, or rvalid outside RDATA
- Completion is still emitted when error sets. 4 KB boundary crossing is not checked; it is the caller's responsibility.

## Timing
- Reset (rst_n low at an edge): state IDLE, all *valid, wr_ready, bready, rready, done_valid, and error = 0. Registered payloads = 0.
- Reset mid-burst: every valid and ready drops at that edge, no done pulse is produced, and the bus transaction is abandoned.
- Command accepted at edge N: awvalid or arvalid is high in cycle N+1.
- W beats can start the cycle after the AW handshake. R data adds zero latency, being combinational from R to rd_*.
- done_valid rises the cycle after the final B or R handshake and lasts exactly one cycle. cmd_ready is high in that same cycle, so back-to-back commands lose no idle cycle beyond it.
- With full throughput, a write of L+1 beats occupies 1 (AW) + L+1 (W) + 1 (B) cycles minimum.

## Test plan
- Single write, id 0x5A, addr 0x0100, len 0, size 2, INCR, data 0xDEADBEEF, strb 0xF → one AW (awaddr 0x0100, awlen 0), one W beat with wlast = 1, done pulse (write = 1, id 0x5A, resp 0). Read back → rd_data 0xDEADBEEF, rd_last 1.
- INCR burst len 3 at 0x0200 with data 1, 2, 3, 4 → wlast only on beat 4. Read back returns 1, 2, 3, 4 with rd_last only on beat 4.
- Backpressure: wr_valid toggles every cycle and rd_ready is held low for 5 cycles mid-read → no beats lost or duplicated, and m_axi_rready = 0 throughout the stall.
- Responder returns bid 0x11 for cmd_id 0x22, and asserts rlast on beat 2 of a len-3 read → error = 1 and stays 1; both done pulses are still emitted.
- rst_n low after 2 of 4 write beats → the next edge shows all valids at 0 and no done pulse. cmd_ready = 1 after release, and a new write completes correctly.
- cmd_size 3 with DATA_WIDTH 32 → awsize = 2 and an address step of 4.
